mem_wb_stage: RTL

//  Memory-stage consumer of the E->M control register. Takes the M-stage control and data,

---
 rtl/mem_wb_stage.sv | 104 ++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: M-stage data-memory access with ready handshake, timeout abort and W-stage register
module mem_wb_stage #(
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteM,
  input  logic [1:0]        ResultSrcM,
  input  logic              MemWriteM,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [REG_W-1:0]  RdM,
  input  logic [DATA_W-1:0] PCPlus4M,
  output logic              MemReq,
  output logic              MemWe,
  output logic [DATA_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWdata,
  input  logic              MemReady,
  input  logic [DATA_W-1:0] MemRdata,
  output logic              StallM,
  output logic              RegWriteW,
  output logic [1:0]        ResultSrcW,
  output logic [DATA_W-1:0] ALUResultW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [REG_W-1:0]  RdW,
  output logic [DATA_W-1:0] PCPlus4W,
  output logic              MemErr
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic in_wait, tmo;
  logic l_rw, l_we;
  logic [1:0] l_rs;
  logic [DATA_W-1:0] l_addr, l_wdata, l_pc;
  logic [REG_W-1:0] l_rd;
  logic cur_rw;
  logic [1:0] cur_rs;
  logic [DATA_W-1:0] cur_pc;
  logic [REG_W-1:0] cur_rd;
  assign in_wait = state == WAIT;
  // In WAIT every request field and retiring field comes from the latched copy, so the
  // memory sees a stable request whatever upstream does with the M inputs.
  always_comb begin
    MemReq   = in_wait | MemWriteM | (ResultSrcM == 2'b01);
    MemWe    = in_wait ? l_we : MemWriteM;
    MemAddr  = in_wait ? l_addr : ALUResultM;
    MemWdata = in_wait ? l_wdata : WriteDataM;
    cur_rw   = in_wait ? l_rw : RegWriteM;
    cur_rs   = in_wait ? l_rs : ResultSrcM;
    cur_rd   = in_wait ? l_rd : RdM;
    cur_pc   = in_wait ? l_pc : PCPlus4M;
    tmo      = in_wait & ~MemReady & (cnt == CNT_W'(TIMEOUT_CYC - 1));
    StallM   = MemReq & ~MemReady & ~tmo;
    state_n  = StallM ? WAIT : IDLE;
  end
  // State, wait counter, request latch, W-stage registers and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      l_rw       <= 1'b0;
      l_we       <= 1'b0;
      l_rs       <= 2'b00;
      l_addr     <= '0;
      l_wdata    <= '0;
      l_rd       <= '0;
      l_pc       <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      RdW        <= '0;
      PCPlus4W   <= '0;
      MemErr     <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= (in_wait & StallM) ? cnt + 1'b1 : '0;
      if (!in_wait) begin
        l_rw    <= RegWriteM;
        l_we    <= MemWriteM;
        l_rs    <= ResultSrcM;
        l_addr  <= ALUResultM;
        l_wdata <= WriteDataM;
        l_rd    <= RdM;
        l_pc    <= PCPlus4M;
      end
      if (StallM) RegWriteW <= 1'b0;
      else begin
        RegWriteW  <= cur_rw;
        ResultSrcW <= cur_rs;
        ALUResultW <= MemAddr;
        RdW        <= cur_rd;
        PCPlus4W   <= cur_pc;
        if (tmo) ReadDataW <= '0;
        else if (cur_rs == 2'b01) ReadDataW <= MemRdata;
      end
      if (tmo) MemErr <= 1'b1;
    end
  end
endmodule
